// File: rtl/apb_sram_ws.sv
// apb_sram_ws: APB4 SRAM slave with byte-addressed access, PSTRB byte-lane
// writes, a programmable number of wait states, a write-protected low region
// and alignment/range error reporting. All outputs are registered.
//
// Handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0).
// It then holds PSEL=1 and PENABLE=1 until the slave raises PREADY for
// exactly one cycle, so the transfer lasts WAIT_CYCLES+2 cycles. PSLVERR is
// valid only while PREADY=1. If PSEL drops while the slave is waiting, the
// transfer is aborted and nothing is written.
//
// dbg_state exposes the FSM state: 0=IDLE, 1=WAIT, 2=DONE.
module apb_sram_ws #(
  parameter int               ADDR_W      = 32,
  parameter int               DATA_W      = 32,
  parameter int               DEPTH       = 64,
  parameter int               WAIT_CYCLES = 0,
  parameter int               RO_WORDS    = 0,
  parameter logic [DATA_W-1:0] RESET_VAL  = '0
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  output logic [1:0]          dbg_state
);

  localparam int BYTES = DATA_W / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  idx_q;
  logic              err_q;
  logic              write_q;
  logic [DATA_W-1:0] mem [DEPTH];

  // Address decode of the current bus request.
  logic [ADDR_W-1:0] d_idx;
  logic              d_range;
  logic              d_misal;
  logic              d_ro;
  logic              d_err;
  logic              setup;

  assign d_idx   = PADDR >> LSB;
  assign d_range = (d_idx >= ADDR_W'(DEPTH));
  assign d_err   = d_range | d_misal | d_ro;
  assign setup   = PSEL & ~PENABLE;

  if (LSB > 0) begin : g_align
    assign d_misal = |PADDR[LSB-1:0];
  end else begin : g_no_align
    assign d_misal = 1'b0;
  end

  if (RO_WORDS > 0) begin : g_ro
    assign d_ro = PWRITE & (d_idx < ADDR_W'(RO_WORDS));
  end else begin : g_no_ro
    assign d_ro = 1'b0;
  end

  // Transfer attributes used when entering DONE: straight from the bus when
  // leaving IDLE, otherwise the copy captured at the setup edge.
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_err;
  logic              sel_write;
  logic              go_done;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    sel_idx   = idx_q;
    sel_err   = err_q;
    sel_write = write_q;
    if (state == S_IDLE) begin
      sel_idx   = d_idx[IDX_W-1:0];
      sel_err   = d_err;
      sel_write = PWRITE;
    end
  end

  assign go_done = ((state == S_IDLE) && setup && (WAIT_CYCLES == 0)) ||
                   ((state == S_WAIT) && PSEL && (cnt == 4'd0));
  assign rd_word = mem[sel_idx];
  assign dbg_state = state;

  // FSM: setup capture, wait-state countdown, abort on PSEL drop.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (setup) begin
            idx_q   <= d_idx[IDX_W-1:0];
            err_q   <= d_err;
            write_q <= PWRITE;
            if (WAIT_CYCLES == 0) begin
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (!PSEL)              state <= S_IDLE;
          else if (cnt == 4'd0)   state <= S_DONE;
          else                    cnt   <= cnt - 4'd1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered response: PREADY/PSLVERR/PRDATA set on entering DONE, cleared on exit.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else if (go_done) begin
      PREADY  <= 1'b1;
      PSLVERR <= sel_err;
      if (!sel_write) PRDATA <= sel_err ? '0 : rd_word;
    end else if (state == S_DONE) begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end
  end

  // Storage: reset fill, and byte-lane merge of a good write at the DONE exit edge.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
    end else if ((state == S_DONE) && write_q && !err_q) begin
      for (int b = 0; b < BYTES; b++) begin
        if (PSTRB[b]) mem[idx_q][8*b +: 8] <= PWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_sram_ws.sv
// tb_apb_sram_ws: three apb_sram_ws instances (no wait / 3 waits with a
// 4-word protected region / 2 waits) sharing one APB bus, each with its own
// PSEL and PRESET. Directed vector table, hand-written multi-cycle corner
// cases, then randomized traffic checked against a word-array reference model.
module tb_apb_sram_ws;

  localparam logic [31:0] RV = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic [2:0]  psel = '0;
  logic [2:0]  prst = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata_v [3];
  logic [2:0]  pready_v;
  logic [2:0]  pslverr_v;
  logic [1:0]  dbg_v [3];

  int n_cmp = 0;
  int n_fail = 0;

  int dut_wait [3] = '{0, 3, 2};
  int dut_ro   [3] = '{0, 4, 0};

  // Clock
  always #5 clk = ~clk;

  apb_sram_ws #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(0), .RO_WORDS(0), .RESET_VAL(RV)) u_d0 (
    .PCLK(clk), .PRESET(prst[0]), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata_v[0]),
    .PREADY(pready_v[0]), .PSLVERR(pslverr_v[0]), .dbg_state(dbg_v[0]));

  apb_sram_ws #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(3), .RO_WORDS(4), .RESET_VAL(RV)) u_d1 (
    .PCLK(clk), .PRESET(prst[1]), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata_v[1]),
    .PREADY(pready_v[1]), .PSLVERR(pslverr_v[1]), .dbg_state(dbg_v[1]));

  apb_sram_ws #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(2), .RO_WORDS(0), .RESET_VAL(RV)) u_d2 (
    .PCLK(clk), .PRESET(prst[2]), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata_v[2]),
    .PREADY(pready_v[2]), .PSLVERR(pslverr_v[2]), .dbg_state(dbg_v[2]));

  // Scoreboard helper
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: one complete APB transfer on instance k; returns data, error and
  // the access-cycle number in which PREADY was seen.
  task automatic apb_xfer(input int k, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          output logic [31:0] rd, output bit err, output int lat);
    bit to;
    psel[k] = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 1; to = 1'b0;
    while (!pready_v[k] && !to) begin
      @(posedge clk); #1;
      lat++;
      if (lat > 40) to = 1'b1;
    end
    if (to) chk("pready_timeout", 64'(lat), 64'(dut_wait[k] + 1));
    rd = prdata_v[k];
    err = pslverr_v[k];
    @(posedge clk); #1;
    chk("pready_one_cycle", 64'(pready_v[k]), 64'd0);
    psel[k] = 1'b0; penable = 1'b0;
  endtask

  // Reference model: plain word array with byte merge; PRDATA holds on writes.
  logic [31:0] mdl [64];
  logic [31:0] last_rd;

  function automatic void ref_reset();
    for (int i = 0; i < 64; i++) mdl[i] = RV;
    last_rd = '0;
  endfunction

  function automatic void ref_xfer(input int ro, input bit wr, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] strb,
                                   output bit e, output logic [31:0] rd);
    int unsigned idx;
    idx = addr / 4;
    e = (idx >= 64) || (addr % 4 != 0) || (wr && (idx < ro));
    if (!wr) begin
      rd = e ? 32'h0 : mdl[idx];
      last_rd = rd;
    end else begin
      rd = last_rd;
      if (!e) for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][8*b +: 8] = wdata[8*b +: 8];
    end
  endfunction

  task automatic pulse_reset(input logic [2:0] which);
    prst = which;
    @(posedge clk); #1;
    prst = '0;
  endtask

  typedef struct {
    int          k;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] rd, exp_rd, addr, wdata;
    logic [3:0]  strb;
    bit          err, exp_err, wr, hit;
    int          lat;

    vecs[0]  = '{0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0, 1};
    vecs[1]  = '{0, 1'b0, 32'h10,  32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1};
    vecs[2]  = '{0, 1'b1, 32'h10,  32'h11223344, 4'h5, 1'b0, 32'h0,        1'b0, 1};
    vecs[3]  = '{0, 1'b0, 32'h10,  32'h0,        4'hF, 1'b1, 32'hDE22BE44, 1'b0, 1};
    vecs[4]  = '{0, 1'b1, 32'h20,  32'h55667788, 4'h0, 1'b0, 32'h0,        1'b0, 1};
    vecs[5]  = '{0, 1'b0, 32'h20,  32'h0,        4'h0, 1'b1, RV,           1'b0, 1};
    vecs[6]  = '{0, 1'b0, 32'h100, 32'h0,        4'h0, 1'b1, 32'h0,        1'b1, 1};
    vecs[7]  = '{0, 1'b1, 32'h12,  32'h12345678, 4'hF, 1'b0, 32'h0,        1'b1, 1};
    vecs[8]  = '{0, 1'b0, 32'h10,  32'h0,        4'h0, 1'b1, 32'hDE22BE44, 1'b0, 1};
    vecs[9]  = '{0, 1'b0, 32'h12,  32'h0,        4'h0, 1'b1, 32'h0,        1'b1, 1};
    vecs[10] = '{1, 1'b0, 32'h40,  32'h0,        4'h0, 1'b1, RV,           1'b0, 4};
    vecs[11] = '{1, 1'b1, 32'h08,  32'h00000000, 4'hF, 1'b0, 32'h0,        1'b1, 4};
    vecs[12] = '{1, 1'b0, 32'h08,  32'h0,        4'h0, 1'b1, RV,           1'b0, 4};
    vecs[13] = '{1, 1'b1, 32'h10,  32'h01020304, 4'hF, 1'b0, 32'h0,        1'b0, 4};
    vecs[14] = '{1, 1'b0, 32'h10,  32'h0,        4'h0, 1'b1, 32'h01020304, 1'b0, 4};
    vecs[15] = '{1, 1'b0, 32'h0C,  32'h0,        4'h0, 1'b1, RV,           1'b0, 4};

    // Reset state of every instance
    prst = 3'b111;
    repeat (2) @(posedge clk);
    #1 prst = '0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_pready",  64'(pready_v[k]),  64'd0);
      chk("rst_pslverr", 64'(pslverr_v[k]), 64'd0);
      chk("rst_prdata",  64'(prdata_v[k]),  64'd0);
      chk("rst_state",   64'(dbg_v[k]),     64'd0);
    end

    // Directed vector table, transfers back-to-back
    for (int i = 0; i < 16; i++) begin
      apb_xfer(vecs[i].k, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, err, lat);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
    end

    // PSEL=1 with PENABLE=1 while idle is not a setup and must be ignored
    psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10; pwdata = '0; pstrb = 4'hF;
    hit = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (pready_v[0]) hit = 1'b1;
    end
    chk("idle_penable_ignored", 64'(hit), 64'd0);
    psel[0] = 1'b0; penable = 1'b0;
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
    chk("after_ignore_rdata", 64'(rd), 64'hDE22BE44);
    chk("after_ignore_lat", 64'(lat), 64'd1);

    // Abort: PSEL drops in the second wait cycle of a write
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h50; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    hit = pready_v[1];
    @(posedge clk); #1;
    if (pready_v[1]) hit = 1'b1;
    psel[1] = 1'b0; penable = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (pready_v[1]) hit = 1'b1;
    end
    chk("abort_no_pready", 64'(hit), 64'd0);
    chk("abort_state_idle", 64'(dbg_v[1]), 64'd0);
    apb_xfer(1, 1'b0, 32'h50, 32'h0, 4'h0, rd, err, lat);
    chk("abort_no_commit", 64'(rd), 64'(RV));
    chk("abort_next_lat", 64'(lat), 64'd4);

    // Reset in the middle of a waited read
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    prst[1] = 1'b1; psel[1] = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    prst[1] = 1'b0;
    chk("midrst_pready",  64'(pready_v[1]),  64'd0);
    chk("midrst_pslverr", 64'(pslverr_v[1]), 64'd0);
    chk("midrst_prdata",  64'(prdata_v[1]),  64'd0);
    for (int i = 0; i < 64; i++) begin
      apb_xfer(1, 1'b0, 32'(i * 4), 32'h0, 4'h0, rd, err, lat);
      chk($sformatf("midrst_word%0d", i), 64'(rd), 64'(RV));
    end

    // Randomized back-to-back traffic against the reference model
    for (int k = 0; k < 3; k++) begin
      pulse_reset(3'(1 << k));
      ref_reset();
      for (int i = 0; i < 64; i++) begin
        wdata = $urandom;
        strb = 4'($urandom_range(0, 15));
        ref_xfer(dut_ro[k], 1'b1, 32'(i * 4), wdata, strb, exp_err, exp_rd);
        apb_xfer(k, 1'b1, 32'(i * 4), wdata, strb, rd, err, lat);
        chk($sformatf("rnd%0d_wr%0d_err", k, i), 64'(err), 64'(exp_err));
        chk($sformatf("rnd%0d_wr%0d_lat", k, i), 64'(lat), 64'(dut_wait[k] + 1));
      end
      for (int i = 0; i < 64; i++) begin
        ref_xfer(dut_ro[k], 1'b0, 32'(i * 4), 32'h0, 4'h0, exp_err, exp_rd);
        apb_xfer(k, 1'b0, 32'(i * 4), 32'h0, 4'h0, rd, err, lat);
        chk($sformatf("rnd%0d_rd%0d_data", k, i), 64'(rd), 64'(exp_rd));
        chk($sformatf("rnd%0d_rd%0d_err", k, i), 64'(err), 64'(exp_err));
      end
      for (int i = 0; i < 40; i++) begin
        wr = 1'($urandom_range(0, 1));
        addr = 32'($urandom_range(0, 32'h11F));
        if ($urandom_range(0, 3) != 0) addr = addr & 32'hFFFF_FFFC;
        wdata = $urandom;
        strb = 4'($urandom_range(0, 15));
        ref_xfer(dut_ro[k], wr, addr, wdata, strb, exp_err, exp_rd);
        apb_xfer(k, wr, addr, wdata, strb, rd, err, lat);
        chk($sformatf("mix%0d_%0d_data", k, i), 64'(rd), 64'(exp_rd));
        chk($sformatf("mix%0d_%0d_err", k, i), 64'(err), 64'(exp_err));
        chk($sformatf("mix%0d_%0d_lat", k, i), 64'(lat), 64'(dut_wait[k] + 1));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
